// File: rtl/matrix_bram_sequencer_if.sv
// Signal bundle around the matrix row BRAM sequencer: control and status,
// element input stream, both BRAM ports and the packed-row output stream.
interface matrix_bram_sequencer_if #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int MAX_ROWS      = 32,
  parameter int MAX_COLS      = 32
);
  localparam int W = ELEMENT_WIDTH * MAX_COLS;

  logic                          start;
  logic [$clog2(MAX_ROWS+1)-1:0] cfg_rows;
  logic [$clog2(MAX_COLS+1)-1:0] cfg_cols;

  logic                          in_valid;
  logic                          in_ready;
  logic [$clog2(MAX_ROWS)-1:0]   in_row;
  logic [$clog2(MAX_COLS)-1:0]   in_col;
  logic [ELEMENT_WIDTH-1:0]      in_element;

  logic                          bram_wea;
  logic [$clog2(MAX_ROWS)-1:0]   bram_addra;
  logic [W-1:0]                  bram_dina;
  logic                          bram_enb;
  logic                          bram_regceb;
  logic [$clog2(MAX_ROWS)-1:0]   bram_addrb;
  logic [W-1:0]                  bram_doutb;

  logic                          out_valid;
  logic                          out_ready;
  logic [$clog2(MAX_ROWS)-1:0]   out_row;
  logic [W-1:0]                  out_data;

  logic                          busy;
  logic                          done;
  logic                          err_order;

  // master is the surrounding system, slave is the sequencer itself
  modport master (
    output start, cfg_rows, cfg_cols, in_valid, in_row, in_col, in_element,
           bram_doutb, out_ready,
    input  in_ready, bram_wea, bram_addra, bram_dina, bram_enb, bram_regceb,
           bram_addrb, out_valid, out_row, out_data, busy, done, err_order
  );

  modport slave (
    input  start, cfg_rows, cfg_cols, in_valid, in_row, in_col, in_element,
           bram_doutb, out_ready,
    output in_ready, bram_wea, bram_addra, bram_dina, bram_enb, bram_regceb,
           bram_addrb, out_valid, out_row, out_data, busy, done, err_order
  );
endinterface

// File: rtl/matrix_bram_sequencer.sv
// Packs a row-major element stream into one BRAM word per row, then reads the
// rows back in order and hands them to the serializer over valid/ready.
module matrix_bram_sequencer #(
  parameter int ELEMENT_WIDTH = 8,
  parameter int MAX_ROWS      = 32,
  parameter int MAX_COLS      = 32,
  parameter int READ_LATENCY  = 2
) (
  input logic                    inter_refclk,
  input logic                    rst,
  matrix_bram_sequencer_if.slave bus
);
  localparam int W   = ELEMENT_WIDTH * MAX_COLS;
  localparam int RW  = $clog2(MAX_ROWS);
  localparam int CW  = $clog2(MAX_COLS);
  localparam int RCW = $clog2(MAX_ROWS + 1);
  localparam int CCW = $clog2(MAX_COLS + 1);
  localparam int LW  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RD_ISSUE, RD_WAIT, SEND, DONE} state_t;
  state_t state, next_state;

  logic [RCW-1:0] rows_q, rows_clamp;
  logic [CCW-1:0] cols_q, cols_clamp;
  logic [RW-1:0]  row_cnt;
  logic [CW-1:0]  col_cnt;
  logic [LW-1:0]  lat_cnt;
  logic [W-1:0]   pack;
  logic           accept, in_match, last_col, last_row, lat_done, out_fire;
  logic           in_ready_d, wea_d, enb_d, regceb_d, out_valid_d, done_d, busy_d;

  assign rows_clamp = (bus.cfg_rows > RCW'(MAX_ROWS)) ? RCW'(MAX_ROWS) : bus.cfg_rows;
  assign cols_clamp = (bus.cfg_cols > CCW'(MAX_COLS)) ? CCW'(MAX_COLS) : bus.cfg_cols;
  assign accept     = (state == LOAD) && bus.in_valid && bus.in_ready;
  assign in_match   = (bus.in_row == row_cnt) && (bus.in_col == col_cnt);
  assign last_col   = (CCW'(col_cnt) == cols_q - CCW'(1));
  assign last_row   = (RCW'(row_cnt) == rows_q - RCW'(1));
  assign lat_done   = (lat_cnt == LW'(READ_LATENCY - 1));
  assign out_fire   = (state == SEND) && bus.out_valid && bus.out_ready;

  // Both BRAM addresses and the write data come straight from registers
  assign bus.bram_addra = row_cnt;
  assign bus.bram_addrb = row_cnt;
  assign bus.bram_dina  = pack;

  always_ff @(posedge inter_refclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.start)
                  next_state = (rows_clamp == '0 || cols_clamp == '0) ? DONE : LOAD;
      LOAD:     if (accept && in_match && last_col) next_state = WRITE;
      WRITE:    next_state = last_row ? RD_ISSUE : LOAD;
      RD_ISSUE: next_state = RD_WAIT;
      RD_WAIT:  if (lat_done) next_state = SEND;
      SEND:     if (out_fire) next_state = last_row ? DONE : RD_ISSUE;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Strobes are decoded from the upcoming state so they register in step with it
  always_comb begin
    in_ready_d  = (next_state == LOAD);
    wea_d       = (next_state == WRITE);
    enb_d       = (next_state == RD_ISSUE);
    regceb_d    = (next_state == RD_WAIT);
    out_valid_d = (next_state == SEND);
    done_d      = (next_state == DONE);
    busy_d      = (next_state != IDLE);
  end

  always_ff @(posedge inter_refclk or negedge rst) begin
    if (!rst) begin
      bus.in_ready    <= 1'b0;
      bus.bram_wea    <= 1'b0;
      bus.bram_enb    <= 1'b0;
      bus.bram_regceb <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.done        <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.in_ready    <= in_ready_d;
      bus.bram_wea    <= wea_d;
      bus.bram_enb    <= enb_d;
      bus.bram_regceb <= regceb_d;
      bus.out_valid   <= out_valid_d;
      bus.done        <= done_d;
      bus.busy        <= busy_d;
    end
  end

  // Counters, pack register and captured output row; the column counter
  // saturates on the last column so it can never wrap at MAX_COLS.
  always_ff @(posedge inter_refclk or negedge rst) begin
    if (!rst) begin
      rows_q        <= '0;
      cols_q        <= '0;
      row_cnt       <= '0;
      col_cnt       <= '0;
      lat_cnt       <= '0;
      pack          <= '0;
      bus.out_data  <= '0;
      bus.out_row   <= '0;
      bus.err_order <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          rows_q        <= rows_clamp;
          cols_q        <= cols_clamp;
          row_cnt       <= '0;
          col_cnt       <= '0;
          pack          <= '0;
          bus.err_order <= 1'b0;
        end
        LOAD: if (accept) begin
          if (in_match) begin
            pack[col_cnt*ELEMENT_WIDTH +: ELEMENT_WIDTH] <= bus.in_element;
            if (!last_col) col_cnt <= col_cnt + CW'(1);
          end else begin
            bus.err_order <= 1'b1;
          end
        end
        WRITE: begin
          pack    <= '0;
          col_cnt <= '0;
          row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        end
        RD_ISSUE: lat_cnt <= '0;
        RD_WAIT: begin
          if (lat_done) begin
            bus.out_data <= bus.bram_doutb;
            bus.out_row  <= row_cnt;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        SEND: if (out_fire && !last_row) row_cnt <= row_cnt + RW'(1);
        default: ;
      endcase
    end
  end
endmodule
